// File: rtl/ddr2_axi_pkg.sv
// ddr2_axi_pkg: shared types and helpers for the DDR2 controller AXI read path.
//   rd_state_e    - read responder FSM state encoding
//   BEAT_W        - width of beat counters (up to 256 beats)
//   decode_arlen  - AXI arlen to beat count (0 encodes 256)
package ddr2_axi_pkg;

  localparam int unsigned BEAT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DRAIN    = 2'd3
  } rd_state_e;

  // arlen of zero means a full 256-beat transfer
  function automatic logic [BEAT_W-1:0] decode_arlen(input logic [7:0] arlen);
    return (arlen == 8'd0) ? BEAT_W'(256) : BEAT_W'(arlen);
  endfunction

endpackage

// File: rtl/rd_resp_fifo.sv
// rd_resp_fifo: synchronous first-word-fall-through FIFO buffering read data.
//   clk, rst        - clock, async active-high reset (flushes contents)
//   push_i/push_data_i - write strobe and data; dropped when full
//   pop_i           - consume head word; ignored when empty
//   head_o          - current head word (zero when empty)
//   empty_o/full_o  - status flags
//   count_o         - number of stored words
module rd_resp_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   head_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  push_ok, pop_ok;

  assign empty_o = (count_q == CNT_W'(0));
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count_q;
  assign head_o  = empty_o ? DATA_WIDTH'(0) : mem_q[rd_ptr_q];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/axi_rd_slave.sv
// axi_rd_slave: AXI read responder for the DDR2 controller.
//   clk, rst          - clock, async active-high reset
//   init_end          - DDR init done; gates AR acceptance
//   axi_ar*           - one read address accepted at a time
//   axi_r*            - read data beats from the response FIFO, rlast on final beat
//   mem_rd_*          - row-safe burst requests to the memory core and returned data
//   busy              - transaction in progress
//   err_ovf           - sticky: memory data arrived while the FIFO was full
module axi_rd_slave
  import ddr2_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned COL_BITS   = 10,
  parameter logic [7:0]  RBURST_LEN = 8'd8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [7:0]            axi_arlen,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic                  axi_rlast,
  output logic                  mem_rd_req,
  input  logic                  mem_rd_ack,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [7:0]            mem_rd_len,
  input  logic                  mem_rd_data_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy,
  output logic                  err_ovf
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW    = ((COL_BITS + 1) > BEAT_W) ? (COL_BITS + 1) : BEAT_W;
  localparam logic [CW-1:0] COL_SPAN = CW'(1 << COL_BITS);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0]     rem_issue_q, rem_issue_d;
  logic [BEAT_W-1:0]     rem_r_q, rem_r_d;
  logic [CNT_W-1:0]      out_q, out_d;
  logic                  arready_q, arready_d;
  logic                  busy_q, busy_d;
  logic                  err_ovf_q, err_ovf_d;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0] fifo_head;

  logic [CW-1:0]         room, chunk, need;
  logic                  credit_ok, pop, commit, req_c;

  rd_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (mem_rd_data_en),
    .push_data_i (mem_rd_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign pop = !fifo_empty && axi_rready;

  // Next burst size: bounded by remaining beats, max burst, and column boundary.
  // Credit counts both buffered words and words still owed by the memory core.
  always_comb begin
    room  = COL_SPAN - CW'(addr_q[COL_BITS-1:0]);
    chunk = CW'(rem_issue_q);
    if (CW'(RBURST_LEN) < chunk) chunk = CW'(RBURST_LEN);
    if (room < chunk)            chunk = room;
    need      = CW'(fifo_count) + CW'(out_q) + chunk;
    credit_ok = (need <= CW'(FIFO_DEPTH));
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_issue_d = rem_issue_q;
    rem_r_d     = pop ? (rem_r_q - BEAT_W'(1)) : rem_r_q;
    req_c       = 1'b0;
    commit      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (axi_arvalid && arready_q) begin
          addr_d      = axi_araddr;
          rem_issue_d = decode_arlen(axi_arlen);
          rem_r_d     = decode_arlen(axi_arlen);
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // An ack landing in the first request cycle is taken immediately
        if (credit_ok) begin
          req_c = 1'b1;
          if (mem_rd_ack) commit  = 1'b1;
          else            state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        req_c = 1'b1;
        if (mem_rd_ack) commit = 1'b1;
      end
      ST_DRAIN: begin
        if (pop && (rem_r_q == BEAT_W'(1))) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      addr_d      = addr_q + ADDR_WIDTH'(chunk);
      rem_issue_d = rem_issue_q - BEAT_W'(chunk);
      state_d     = (rem_issue_d != BEAT_W'(0)) ? ST_ISSUE : ST_DRAIN;
    end

    out_d = out_q + (commit ? CNT_W'(chunk) : CNT_W'(0));
    if (mem_rd_data_en && (out_d != CNT_W'(0))) out_d = out_d - CNT_W'(1);

    arready_d = init_end && (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
    err_ovf_d = err_ovf_q || (mem_rd_data_en && fifo_full);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_issue_q <= '0;
      rem_r_q     <= '0;
      out_q       <= '0;
      arready_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_issue_q <= rem_issue_d;
      rem_r_q     <= rem_r_d;
      out_q       <= out_d;
      arready_q   <= arready_d;
      busy_q      <= busy_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign axi_arready = arready_q;
  assign axi_rvalid  = !fifo_empty;
  assign axi_rdata   = fifo_head;
  assign axi_rlast   = !fifo_empty && (rem_r_q == BEAT_W'(1));
  assign mem_rd_req  = req_c;
  assign mem_rd_addr = addr_q;
  assign mem_rd_len  = 8'(chunk);
  assign busy        = busy_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_axi_rd_slave.sv
// tb_axi_rd_slave: directed bench for axi_rd_slave with a behavioural memory core.
module tb_axi_rd_slave;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_end;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic          axi_rvalid;
  logic          axi_rready;
  logic [DW-1:0] axi_rdata;
  logic          axi_rlast;
  logic          mem_rd_req;
  logic          mem_rd_ack;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_len;
  logic          mem_rd_data_en;
  logic [DW-1:0] mem_rd_data;
  logic          busy;
  logic          err_ovf;

  always #5 clk = ~clk;

  axi_rd_slave dut (
    .clk            (clk),
    .rst            (rst),
    .init_end       (init_end),
    .axi_arvalid    (axi_arvalid),
    .axi_arready    (axi_arready),
    .axi_araddr     (axi_araddr),
    .axi_arlen      (axi_arlen),
    .axi_rvalid     (axi_rvalid),
    .axi_rready     (axi_rready),
    .axi_rdata      (axi_rdata),
    .axi_rlast      (axi_rlast),
    .mem_rd_req     (mem_rd_req),
    .mem_rd_ack     (mem_rd_ack),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_len     (mem_rd_len),
    .mem_rd_data_en (mem_rd_data_en),
    .mem_rd_data    (mem_rd_data),
    .busy           (busy),
    .err_ovf        (err_ovf)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    int            ack_dly;
    int            stall;
    int            beats;
    int            nreq;
    int            stall_reqs;
    logic [AW-1:0] r0a;
    logic [7:0]    r0l;
    logic [AW-1:0] r1a;
    logic [7:0]    r1l;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic [DW-1:0] dq[$];
  beat_t         beats[$];
  logic [AW-1:0] req_a[$];
  logic [7:0]    req_l[$];
  int            ack_dly = 0;
  logic          rready_en = 1'b1;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ DW'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c = 0;
    while (beats.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("beat_timeout", 64'(beats.size() >= n), 64'd1);
  endtask

  task automatic do_ar(input logic [AW-1:0] a, input logic [7:0] l);
    int n = 0;
    @(negedge clk);
    axi_araddr  = a;
    axi_arlen   = l;
    axi_arvalid = 1'b1;
    while (!axi_arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ar_ready_seen", 64'(axi_arready), 64'd1);
    @(negedge clk);
    axi_arvalid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    beats.delete();
    req_a.delete();
    req_l.delete();
    ack_dly   = v.ack_dly;
    rready_en = (v.stall == 0);
    do_ar(v.addr, v.len);
    if (v.stall > 0) begin
      repeat (v.stall) @(negedge clk);
      chk("stall_reqs", 64'(req_a.size()), 64'(v.stall_reqs));
      chk("stall_beats", 64'(beats.size()), 64'd0);
      chk("stall_ovf", 64'(err_ovf), 64'd0);
      rready_en = 1'b1;
    end
    wait_beats(v.beats, 4000);
    repeat (4) @(negedge clk);
    chk("beat_count", 64'(beats.size()), 64'(v.beats));
    chk("busy_after", 64'(busy), 64'd0);
    chk("ovf_after", 64'(err_ovf), 64'd0);
    chk("req_count", 64'(req_a.size()), 64'(v.nreq));
    if (req_a.size() > 0) begin
      chk("req0_addr", 64'(req_a[0]), 64'(v.r0a));
      chk("req0_len", 64'(req_l[0]), 64'(v.r0l));
    end
    if (v.nreq > 1 && req_a.size() > 1) begin
      chk("req1_addr", 64'(req_a[1]), 64'(v.r1a));
      chk("req1_len", 64'(req_l[1]), 64'(v.r1l));
    end
    for (int i = 0; i < beats.size(); i++) begin
      chk("beat_data", 64'(beats[i].data), 64'(word_of(v.addr + AW'(i))));
      chk("beat_last", 64'(beats[i].last), 64'(i == v.beats - 1));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_arready"}, 64'(axi_arready), 64'd0);
    chk({tag, "_rvalid"}, 64'(axi_rvalid), 64'd0);
    chk({tag, "_rdata"}, 64'(axi_rdata), 64'd0);
    chk({tag, "_rlast"}, 64'(axi_rlast), 64'd0);
    chk({tag, "_req"}, 64'(mem_rd_req), 64'd0);
    chk({tag, "_addr"}, 64'(mem_rd_addr), 64'd0);
    chk({tag, "_len"}, 64'(mem_rd_len), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ovf"}, 64'(err_ovf), 64'd0);
  endtask

  // Memory core model: acks after ack_dly cycles, returns len words one per cycle
  initial begin : mem_model
    int            wait_cnt;
    logic          pend;
    logic [AW-1:0] p_a;
    logic [7:0]    p_l;
    wait_cnt       = 0;
    pend           = 1'b0;
    p_a            = '0;
    p_l            = '0;
    mem_rd_ack     = 1'b0;
    mem_rd_data_en = 1'b0;
    mem_rd_data    = '0;
    axi_rready     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_rd_ack     = 1'b0;
        mem_rd_data_en = 1'b0;
        mem_rd_data    = '0;
        axi_rready     = 1'b0;
        dq.delete();
        wait_cnt       = 0;
        pend           = 1'b0;
      end else begin
        if (dq.size() > 0) begin
          mem_rd_data_en = 1'b1;
          mem_rd_data    = dq.pop_front();
        end else begin
          mem_rd_data_en = 1'b0;
          mem_rd_data    = '0;
        end
        mem_rd_ack = 1'b0;
        if (mem_rd_req) begin
          if (pend) begin
            chk("req_hold_addr", 64'(mem_rd_addr), 64'(p_a));
            chk("req_hold_len", 64'(mem_rd_len), 64'(p_l));
          end
          if (wait_cnt >= ack_dly) begin
            mem_rd_ack = 1'b1;
            req_a.push_back(mem_rd_addr);
            req_l.push_back(mem_rd_len);
            for (int i = 0; i < int'(mem_rd_len); i++)
              dq.push_back(word_of(mem_rd_addr + AW'(i)));
            wait_cnt = 0;
            pend     = 1'b0;
          end else begin
            wait_cnt++;
            pend = 1'b1;
            p_a  = mem_rd_addr;
            p_l  = mem_rd_len;
          end
        end else begin
          if (pend) chk("req_hold_req", 64'(mem_rd_req), 64'd1);
          pend     = 1'b0;
          wait_cnt = 0;
        end
        axi_rready = rready_en;
        if (axi_rvalid && axi_rready) beats.push_back('{axi_rdata, axi_rlast});
      end
    end
  end

  initial begin : main
    vec_t vt[6];
    vec_t vr;
    int   n;
    int   nlast;
    vt[0] = '{26'h0000100, 8'd8,  0, 0,   8,   1,  0, 26'h0000100, 8'd8, 26'h0000000, 8'd0};
    vt[1] = '{26'h00003FC, 8'd8,  0, 0,   8,   2,  0, 26'h00003FC, 8'd4, 26'h0000400, 8'd4};
    vt[2] = '{26'h0000000, 8'd0,  0, 300, 256, 32, 2, 26'h0000000, 8'd8, 26'h0000008, 8'd8};
    vt[3] = '{26'h3FFFFFF, 8'd2,  0, 0,   2,   2,  0, 26'h3FFFFFF, 8'd1, 26'h0000000, 8'd1};
    vt[4] = '{26'h0000020, 8'd5,  5, 0,   5,   1,  0, 26'h0000020, 8'd5, 26'h0000000, 8'd0};
    vt[5] = '{26'h00003F9, 8'd20, 2, 0,   20,  3,  0, 26'h00003F9, 8'd7, 26'h0000400, 8'd8};
    vr    = '{26'h0000180, 8'd8,  0, 0,   8,   1,  0, 26'h0000180, 8'd8, 26'h0000000, 8'd0};

    rst         = 1'b1;
    init_end    = 1'b0;
    axi_arvalid = 1'b0;
    axi_araddr  = '0;
    axi_arlen   = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // AR blocked until init_end, then accepted the following cycle
    axi_araddr  = 26'h40;
    axi_arlen   = 8'd1;
    axi_arvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("arready_no_init", 64'(axi_arready), 64'd0);
    end
    init_end = 1'b1;
    @(negedge clk);
    chk("arready_init", 64'(axi_arready), 64'd1);
    @(negedge clk);
    axi_arvalid = 1'b0;
    chk("busy_start", 64'(busy), 64'd1);
    chk("arready_drop", 64'(axi_arready), 64'd0);
    chk("first_req", 64'(mem_rd_req), 64'd1);
    chk("first_req_addr", 64'(mem_rd_addr), 64'h40);
    chk("first_req_len", 64'(mem_rd_len), 64'd1);
    wait_beats(1, 100);
    if (beats.size() > 0) begin
      chk("init_data", 64'(beats[0].data), 64'(word_of(26'h40)));
      chk("init_last", 64'(beats[0].last), 64'd1);
    end
    repeat (3) @(negedge clk);
    chk("init_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) run_txn(vt[i]);

    // Reset during the R phase aborts the transaction
    beats.delete();
    req_a.delete();
    req_l.delete();
    ack_dly   = 0;
    rready_en = 1'b1;
    do_ar(26'h200, 8'd8);
    n = 0;
    while (beats.size() < 3 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_beats_seen", 64'(beats.size()), 64'd3);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_no_more_beats", 64'(beats.size()), 64'd3);
    nlast = 0;
    foreach (beats[i]) if (beats[i].last) nlast++;
    chk("rst_no_rlast", 64'(nlast), 64'd0);
    run_txn(vr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
